// File: rtl/dmu_sii_tx.sv
// dmu_sii_tx: DMU-side transmitter for the DMU->SII inbound request interface.
// Requests are registered in IDLE, their payload is collected into a 4-entry
// buffer in LOAD, and a write waits in WAITC for a write credit. The packet
// then goes out as one header cycle (HDR) and its payload beats (PAY). Every
// SII-facing output, including parity, is a register.
module dmu_sii_tx #(
  parameter int WR_CREDITS = 16
) (
  input  logic         iol2clk,
  input  logic         rst,
  input  logic         req_vld,
  output logic         req_rdy,
  input  logic [1:0]   req_type,
  input  logic         req_bypass,
  input  logic [15:0]  req_tag,
  input  logic [39:0]  req_pa,
  input  logic [15:0]  req_be,
  input  logic         pl_vld,
  output logic         pl_rdy,
  input  logic [127:0] pl_data,
  output logic         dmu_sii_hdr_vld,
  output logic         dmu_sii_reqbypass,
  output logic         dmu_sii_datareq,
  output logic         dmu_sii_datareq16,
  output logic [127:0] dmu_sii_data,
  output logic [7:0]   dmu_sii_parity,
  output logic [15:0]  dmu_sii_be,
  input  logic         sii_dmu_wrack_vld,
  input  logic [3:0]   sii_dmu_wrack_tag,
  output logic [4:0]   credit_cnt,
  output logic         credit_ovf
);

  localparam logic [1:0] TYPE_RD    = 2'b00;
  localparam logic [1:0] TYPE_WR    = 2'b01;
  localparam logic [1:0] TYPE_MONDO = 2'b10;
  localparam logic [1:0] TYPE_PIO   = 2'b11;
  localparam logic [4:0] CREDIT_MAX = 5'(WR_CREDITS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAITC = 3'd2,
    S_HDR   = 3'd3,
    S_PAY   = 3'd4
  } state_t;

  state_t         state_reg;
  state_t         state_next;
  logic [1:0]     type_reg;
  logic           bypass_reg;
  logic [15:0]    tag_reg;
  logic [39:0]    pa_reg;
  logic [15:0]    be_reg;
  logic [127:0]   pl_buf [4];
  logic [1:0]     beat_reg;
  logic [4:0]     credit_reg;
  logic           ovf_reg;

  logic           req_rdy_reg;
  logic           pl_rdy_reg;
  logic           hdr_vld_reg;
  logic           reqbypass_reg;
  logic           datareq_reg;
  logic           datareq16_reg;
  logic [127:0]   data_reg;
  logic [127:0]   data_next;
  logic [7:0]     parity_reg;
  logic [15:0]    be_out_reg;

  logic           accept;
  logic           beat_acc;
  logic           is_wr;
  logic           is_rd;
  logic [1:0]     last_idx;
  logic [1:0]     beat_inc;
  logic           load_done;
  logic           last_beat;
  logic           credit_inc;
  logic           credit_dec;

  // The returned credit tag carries no information the counter needs.
  logic           unused_wrack_tag;
  assign unused_wrack_tag = ^sii_dmu_wrack_tag;

  assign accept     = (state_reg == S_IDLE) && req_vld && req_rdy_reg;
  assign beat_acc   = (state_reg == S_LOAD) && pl_vld && pl_rdy_reg;
  assign is_wr      = (type_reg == TYPE_WR);
  assign is_rd      = (type_reg == TYPE_RD);
  assign last_idx   = is_wr ? 2'd3 : 2'd0;
  assign beat_inc   = beat_reg + 2'd1;
  assign load_done  = beat_acc && (beat_reg == last_idx);
  assign last_beat  = (beat_reg == last_idx);
  assign credit_inc = sii_dmu_wrack_vld;
  assign credit_dec = (state_reg == S_HDR) && is_wr;

  // Next-state decode; a write may only leave WAITC with a credit in hand.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = (req_type == TYPE_RD) ? S_WAITC : S_LOAD;
      S_LOAD:  if (load_done) state_next = is_wr ? S_WAITC : S_HDR;
      S_WAITC: if (!(is_wr && (credit_reg == 5'd0))) state_next = S_HDR;
      S_HDR:   state_next = is_rd ? S_IDLE : S_PAY;
      S_PAY:   if (last_beat) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Value the SII data bus takes next: header, next buffered beat, or zero.
  always_comb begin
    data_next = '0;
    if (state_next == S_HDR) begin
      data_next[79:64] = tag_reg;
      data_next[39:0]  = pa_reg;
    end else if (state_next == S_PAY) begin
      data_next = (state_reg == S_HDR) ? pl_buf[2'd0] : pl_buf[beat_inc];
    end
  end

  // FSM, request/payload capture, credit counter and registered outputs.
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      type_reg      <= TYPE_RD;
      bypass_reg    <= 1'b0;
      tag_reg       <= '0;
      pa_reg        <= '0;
      be_reg        <= '0;
      for (int i = 0; i < 4; i++) pl_buf[i] <= '0;
      beat_reg      <= '0;
      credit_reg    <= CREDIT_MAX;
      ovf_reg       <= 1'b0;
      req_rdy_reg   <= 1'b0;
      pl_rdy_reg    <= 1'b0;
      hdr_vld_reg   <= 1'b0;
      reqbypass_reg <= 1'b0;
      datareq_reg   <= 1'b0;
      datareq16_reg <= 1'b0;
      data_reg      <= '0;
      be_out_reg    <= '0;
    end else begin
      state_reg <= state_next;

      if (accept) begin
        type_reg <= req_type;
        tag_reg  <= req_tag;
        pa_reg   <= req_pa;
        be_reg   <= req_be;
        // Mondo always targets the ordered queue, PIO completions the bypass.
        case (req_type)
          TYPE_MONDO: bypass_reg <= 1'b0;
          TYPE_PIO:   bypass_reg <= 1'b1;
          default:    bypass_reg <= req_bypass;
        endcase
      end

      if (beat_acc) begin
        pl_buf[beat_reg] <= pl_data;
        beat_reg         <= load_done ? 2'd0 : beat_inc;
      end else if (state_reg == S_PAY) begin
        beat_reg <= last_beat ? 2'd0 : beat_inc;
      end

      if (credit_inc && !credit_dec) begin
        if (credit_reg == CREDIT_MAX) ovf_reg <= 1'b1;
        else credit_reg <= credit_reg + 5'd1;
      end else if (!credit_inc && credit_dec) begin
        credit_reg <= credit_reg - 5'd1;
      end

      req_rdy_reg   <= (state_next == S_IDLE);
      pl_rdy_reg    <= (state_next == S_LOAD);
      hdr_vld_reg   <= (state_next == S_HDR);
      reqbypass_reg <= ((state_next == S_HDR) || (state_next == S_PAY)) && bypass_reg;
      datareq_reg   <= (state_next == S_HDR) && !is_rd;
      datareq16_reg <= (state_next == S_HDR) && type_reg[1];
      be_out_reg    <= ((state_next == S_HDR) && is_wr) ? be_reg : 16'h0;
      data_reg      <= data_next;
    end
  end

  // One parity bit per 16-bit lane, registered alongside the data it covers.
  for (genvar gi = 0; gi < 8; gi++) begin : g_parity
    always_ff @(posedge iol2clk) begin
      if (rst) parity_reg[gi] <= 1'b0;
      else     parity_reg[gi] <= ^data_next[16*gi +: 16];
    end
  end

  assign req_rdy           = req_rdy_reg;
  assign pl_rdy            = pl_rdy_reg;
  assign dmu_sii_hdr_vld   = hdr_vld_reg;
  assign dmu_sii_reqbypass = reqbypass_reg;
  assign dmu_sii_datareq   = datareq_reg;
  assign dmu_sii_datareq16 = datareq16_reg;
  assign dmu_sii_data      = data_reg;
  assign dmu_sii_parity    = parity_reg;
  assign dmu_sii_be        = be_out_reg;
  assign credit_cnt        = credit_reg;
  assign credit_ovf        = ovf_reg;

endmodule

// File: tb/tb_dmu_sii_tx.sv
// Testbench for dmu_sii_tx. Two instances: dut_a (16 credits) runs the vector
// table and the overflow/reset sequences, dut_b (2 credits) runs the credit
// exhaustion sequence. sel steers the shared stimulus and the observed outputs.
module tb_dmu_sii_tx;

  logic iol2clk = 1'b0;
  always #5 iol2clk = ~iol2clk;

  logic         rst;
  logic         sel;
  logic         req_vld;
  logic [1:0]   req_type;
  logic         req_bypass;
  logic [15:0]  req_tag;
  logic [39:0]  req_pa;
  logic [15:0]  req_be;
  logic         pl_vld;
  logic [127:0] pl_data;
  logic         wrack;
  logic [3:0]   wrack_tag;

  logic         a_req_rdy, b_req_rdy, a_pl_rdy, b_pl_rdy;
  logic         a_hdr, b_hdr, a_byp, b_byp, a_dr, b_dr, a_dr16, b_dr16;
  logic [127:0] a_data, b_data;
  logic [7:0]   a_par, b_par;
  logic [15:0]  a_be, b_be;
  logic [4:0]   a_credit, b_credit;
  logic         a_ovf, b_ovf;

  dmu_sii_tx #(.WR_CREDITS(16)) dut_a (
    .iol2clk(iol2clk), .rst(rst),
    .req_vld(req_vld && !sel), .req_rdy(a_req_rdy), .req_type(req_type),
    .req_bypass(req_bypass), .req_tag(req_tag), .req_pa(req_pa), .req_be(req_be),
    .pl_vld(pl_vld && !sel), .pl_rdy(a_pl_rdy), .pl_data(pl_data),
    .dmu_sii_hdr_vld(a_hdr), .dmu_sii_reqbypass(a_byp), .dmu_sii_datareq(a_dr),
    .dmu_sii_datareq16(a_dr16), .dmu_sii_data(a_data), .dmu_sii_parity(a_par),
    .dmu_sii_be(a_be), .sii_dmu_wrack_vld(wrack && !sel), .sii_dmu_wrack_tag(wrack_tag),
    .credit_cnt(a_credit), .credit_ovf(a_ovf)
  );

  dmu_sii_tx #(.WR_CREDITS(2)) dut_b (
    .iol2clk(iol2clk), .rst(rst),
    .req_vld(req_vld && sel), .req_rdy(b_req_rdy), .req_type(req_type),
    .req_bypass(req_bypass), .req_tag(req_tag), .req_pa(req_pa), .req_be(req_be),
    .pl_vld(pl_vld && sel), .pl_rdy(b_pl_rdy), .pl_data(pl_data),
    .dmu_sii_hdr_vld(b_hdr), .dmu_sii_reqbypass(b_byp), .dmu_sii_datareq(b_dr),
    .dmu_sii_datareq16(b_dr16), .dmu_sii_data(b_data), .dmu_sii_parity(b_par),
    .dmu_sii_be(b_be), .sii_dmu_wrack_vld(wrack && sel), .sii_dmu_wrack_tag(wrack_tag),
    .credit_cnt(b_credit), .credit_ovf(b_ovf)
  );

  wire         m_req_rdy = sel ? b_req_rdy : a_req_rdy;
  wire         m_pl_rdy  = sel ? b_pl_rdy  : a_pl_rdy;
  wire         m_hdr     = sel ? b_hdr     : a_hdr;
  wire         m_byp     = sel ? b_byp     : a_byp;
  wire         m_dr      = sel ? b_dr      : a_dr;
  wire         m_dr16    = sel ? b_dr16    : a_dr16;
  wire [127:0] m_data    = sel ? b_data    : a_data;
  wire [7:0]   m_par     = sel ? b_par     : a_par;
  wire [15:0]  m_be      = sel ? b_be      : a_be;
  wire [4:0]   m_credit  = sel ? b_credit  : a_credit;
  wire         m_ovf     = sel ? b_ovf     : a_ovf;

  typedef struct {
    logic [1:0]         typ;
    logic               byp;
    logic [15:0]        tag;
    logic [39:0]        pa;
    logic [15:0]        be;
    logic [3:0][127:0]  beat;
    int                 nbeat;
    int                 gap;
    logic               wrack_hdr;
    int                 exp_lat;
    logic               exp_dr;
    logic               exp_dr16;
    logic               exp_byp;
    logic [15:0]        exp_be;
    logic [7:0]         exp_hpar;
    logic [3:0][7:0]    exp_ppar;
    logic [4:0]         exp_credit;
  } vec_t;

  vec_t vtab [6];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iol2clk);
    #1;
  endtask

  task automatic pulse_wrack();
    wrack = 1'b1;
    tick();
    wrack = 1'b0;
  endtask

  task automatic send_req(input vec_t v);
    int n;
    req_type = v.typ; req_bypass = v.byp; req_tag = v.tag; req_pa = v.pa; req_be = v.be;
    req_vld = 1'b1;
    n = 0;
    while (!m_req_rdy && n < 20) begin tick(); n++; end
    chk("req_rdy_timeout", 128'(n < 20), 128'd1);
    tick();
    req_vld = 1'b0;
  endtask

  task automatic feed_beats(input vec_t v);
    int n;
    for (int k = 0; k < v.nbeat; k++) begin
      for (int g = 0; g < v.gap; g++) tick();
      pl_vld = 1'b1;
      pl_data = v.beat[k];
      n = 0;
      while (!m_pl_rdy && n < 20) begin tick(); n++; end
      chk("pl_rdy_timeout", 128'(n < 20), 128'd1);
      tick();
      pl_vld = 1'b0;
    end
    chk("pl_rdy_after_load", 128'(m_pl_rdy), 128'd0);
  endtask

  // From the end of loading: wait for the header, check it, its payload and
  // the idle cycle that follows.
  task automatic check_packet(input vec_t v);
    int n;
    n = 0;
    while (!m_hdr && n < 20) begin tick(); n++; end
    chk("hdr_latency", 128'(n), 128'(v.exp_lat));
    if (v.wrack_hdr) wrack = 1'b1;
    chk("hdr_datareq", 128'(m_dr), 128'(v.exp_dr));
    chk("hdr_datareq16", 128'(m_dr16), 128'(v.exp_dr16));
    chk("hdr_reqbypass", 128'(m_byp), 128'(v.exp_byp));
    chk("hdr_be", 128'(m_be), 128'(v.exp_be));
    chk("hdr_data", m_data, {48'h0, v.tag, 24'h0, v.pa});
    chk("hdr_parity", 128'(m_par), 128'(v.exp_hpar));
    for (int k = 0; k < v.nbeat; k++) begin
      tick();
      wrack = 1'b0;
      chk("pay_ctrl", {m_hdr, m_dr, m_dr16, m_be}, 128'h0);
      chk("pay_reqbypass", 128'(m_byp), 128'(v.exp_byp));
      chk("pay_data", m_data, v.beat[k]);
      chk("pay_parity", 128'(m_par), 128'(v.exp_ppar[k]));
    end
    tick();
    wrack = 1'b0;
    chk("idle_outputs", {m_hdr, m_byp, m_dr, m_dr16, m_be, m_par}, 128'h0);
    chk("idle_data", m_data, 128'h0);
    chk("idle_req_rdy", 128'(m_req_rdy), 128'd1);
    chk("credit_after_pkt", 128'(m_credit), 128'(v.exp_credit));
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    $display("txn %0d: type=%0d tag=%h pa=%h be=%h beats=%0d", idx, v.typ, v.tag, v.pa, v.be, v.nbeat);
    send_req(v);
    feed_beats(v);
    check_packet(v);
  endtask

  initial begin
    vec_t w;
    int   n;
    vtab[0] = '{2'b00, 1'b1, 16'h1234, 40'h12_3456_7890, 16'h0000, 512'h0,
                0, 0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h12, 32'h0, 5'd16};
    vtab[1] = '{2'b01, 1'b0, 16'h0001, 40'h00_8000_0040, 16'hFFFF,
                {{8{16'hDDDD}}, {8{16'hCCCC}}, {8{16'hBBBB}}, {8{16'hAAAA}}},
                4, 1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 8'h13, 32'h0, 5'd15};
    vtab[2] = '{2'b10, 1'b1, 16'h00AB, 40'h0, 16'h1234, {384'h0, {8{16'h1111}}},
                1, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h10, 32'h0, 5'd15};
    vtab[3] = '{2'b11, 1'b0, 16'h0C05, 40'h00_0000_1000, 16'h0000, {384'h0, {8{16'h5555}}},
                1, 0, 1'b0, 0, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h01, 32'h0, 5'd15};
    vtab[4] = '{2'b01, 1'b1, 16'h0002, 40'h3, 16'h00F0,
                {128'h0, 128'h7, 128'h3, 128'h1},
                4, 0, 1'b1, 1, 1'b1, 1'b0, 1'b1, 16'h00F0, 8'h10, 32'h0001_0001, 5'd15};
    vtab[5] = '{2'b00, 1'b0, 16'hFFFF, 40'h01_0000_0007, 16'h0000, 512'h0,
                0, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h05, 32'h0, 5'd15};

    rst = 1'b1; sel = 1'b0; req_vld = 1'b0; req_type = '0; req_bypass = 1'b0;
    req_tag = '0; req_pa = '0; req_be = '0; pl_vld = 1'b0; pl_data = '0;
    wrack = 1'b0; wrack_tag = 4'h3;
    repeat (3) tick();
    chk("rst_rdy", {a_req_rdy, a_pl_rdy, b_req_rdy, b_pl_rdy}, 128'h0);
    chk("rst_ctrl", {a_hdr, a_byp, a_dr, a_dr16, a_be, a_par}, 128'h0);
    chk("rst_data", a_data, 128'h0);
    chk("rst_credit_a", 128'(a_credit), 128'd16);
    chk("rst_credit_b", 128'(b_credit), 128'd2);
    chk("rst_ovf", 128'(a_ovf), 128'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vtab[i], i);

    // Credit return with a full counter saturates and sets the sticky flag.
    $display("txn ovf: two wrack pulses at credit 15");
    pulse_wrack();
    chk("credit_refill", 128'(a_credit), 128'd16);
    chk("ovf_not_yet", 128'(a_ovf), 128'd0);
    pulse_wrack();
    chk("credit_saturate", 128'(a_credit), 128'd16);
    chk("ovf_set", 128'(a_ovf), 128'd1);
    tick();
    chk("ovf_sticky", 128'(a_ovf), 128'd1);

    // Reset on the second payload beat of a write abandons the packet.
    $display("txn rst: write interrupted by reset on payload beat 1");
    w = vtab[1];
    send_req(w);
    feed_beats(w);
    n = 0;
    while (!a_hdr && n < 20) begin tick(); n++; end
    chk("rst_seq_hdr", 128'(n), 128'd1);
    tick();
    chk("rst_seq_beat0", a_data, w.beat[0]);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ctrl", {a_req_rdy, a_pl_rdy, a_hdr, a_byp, a_dr, a_dr16, a_be, a_par}, 128'h0);
    chk("midrst_data", a_data, 128'h0);
    chk("midrst_credit", 128'(a_credit), 128'd16);
    chk("midrst_ovf", 128'(a_ovf), 128'd0);
    run_vec(vtab[0], 6);

    // Two credits: third write waits until a credit comes back.
    sel = 1'b1;
    w = vtab[1];
    w.gap = 0;
    w.exp_credit = 5'd1;
    run_vec(w, 7);
    w.exp_credit = 5'd0;
    run_vec(w, 8);
    $display("txn 9: third write on exhausted credits");
    send_req(w);
    feed_beats(w);
    n = 0;
    for (int c = 0; c < 5; c++) begin
      if (m_hdr) n++;
      if (c < 4) tick();
    end
    chk("waitc_no_hdr", 128'(n), 128'd0);
    chk("waitc_credit", 128'(m_credit), 128'd0);
    pulse_wrack();
    chk("wrack_credit", 128'(m_credit), 128'd1);
    chk("wrack_no_hdr_yet", 128'(m_hdr), 128'd0);
    check_packet(w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
